// File: rtl/agp32_mem_responder.sv
// agp32_mem_responder: word-array memory responder for the agp32 command/ready interface
module agp32_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        command,
    input  logic [31:0]       PC,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_wstrb,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              load_done,
    output logic              ready,
    output logic [31:0]       inst_rdata,
    output logic [31:0]       data_rdata,
    output logic              mem_start_ready,
    output logic [1:0]        error
);
    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_BUSY, S_ERR} state_t;

    localparam logic [3:0] L_CNT = 4'(LATENCY - 1);

    logic [31:0]       r_mem [2**ADDR_W];
    state_t            r_state;
    state_t            w_state_n;
    logic [3:0]        r_cnt;
    logic [2:0]        r_cmd;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_oor;
    logic              w_accept;
    logic              w_illegal;
    logic              w_fin;
    logic              w_ok;
    logic              w_oor_in;
    logic              w_ready_n;
    logic              w_msr_n;
    logic [1:0]        w_err_n;
    logic [3:0]        w_we;
    logic [ADDR_W-1:0] w_widx;
    logic [31:0]       w_wdat;
    logic              w_unused;

    // Byte offsets never select anything: the array is word-addressed.
    assign w_unused  = ^{PC[1:0], data_addr[1:0]};
    assign w_accept  = (r_state == S_IDLE) && (command != 3'd0) && (command <= 3'd4);
    assign w_illegal = (r_state == S_IDLE) && (command >= 3'd5);
    assign w_fin     = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_ok      = w_fin && !r_oor;
    // Range fault is decided at acceptance from the address the command actually uses.
    assign w_oor_in  = (command == 3'd1) ? |PC[31:ADDR_W+2] :
                       (command == 3'd2 || command == 3'd3) ? |data_addr[31:ADDR_W+2] : 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_state_n;
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_LOAD:  w_state_n = load_done ? S_IDLE : S_LOAD;
            S_IDLE:  w_state_n = w_accept ? S_BUSY : (w_illegal ? S_ERR : S_IDLE);
            S_BUSY:  w_state_n = w_fin ? (r_oor ? S_ERR : S_IDLE) : S_BUSY;
            default: w_state_n = S_ERR;
        endcase
    end

    // Next values of the registered outputs and the array write port
    always_comb begin
        w_ready_n = ready;
        w_msr_n   = mem_start_ready;
        w_err_n   = error;
        w_we      = 4'b0000;
        w_widx    = ld_addr;
        w_wdat    = ld_data;
        case (r_state)
            S_LOAD: begin
                w_we = {4{ld_we}};
                if (load_done) begin
                    w_ready_n = 1'b1;
                    w_msr_n   = 1'b1;
                end
            end
            S_IDLE: begin
                if (w_accept) w_ready_n = 1'b0;
                if (w_illegal) begin
                    w_ready_n = 1'b0;
                    w_err_n   = 2'd2;
                end
            end
            S_BUSY: begin
                if (w_fin && r_oor) w_err_n = 2'd1;
                if (w_ok) begin
                    w_ready_n = 1'b1;
                    if (r_cmd == 3'd3) begin
                        w_we   = r_wstrb;
                        w_widx = r_addr;
                        w_wdat = r_wdata;
                    end
                end
            end
            default: w_ready_n = 1'b0;
        endcase
    end

    // Registered outputs, command latches and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready           <= 1'b0;
            mem_start_ready <= 1'b0;
            error           <= 2'd0;
            inst_rdata      <= 32'd0;
            data_rdata      <= 32'd0;
            r_cnt           <= 4'd0;
            r_cmd           <= 3'd0;
            r_pc            <= '0;
            r_addr          <= '0;
            r_wdata         <= 32'd0;
            r_wstrb         <= 4'd0;
            r_oor           <= 1'b0;
        end else begin
            ready           <= w_ready_n;
            mem_start_ready <= w_msr_n;
            error           <= w_err_n;
            if (w_accept) begin
                r_cnt   <= L_CNT;
                r_cmd   <= command;
                r_pc    <= PC[ADDR_W+1:2];
                r_addr  <= data_addr[ADDR_W+1:2];
                r_wdata <= data_wdata;
                r_wstrb <= data_wstrb;
                r_oor   <= w_oor_in;
            end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_ok && r_cmd == 3'd1) inst_rdata <= r_mem[r_pc];
            if (w_ok && r_cmd == 3'd2) data_rdata <= r_mem[r_addr];
        end
    end

    // Byte-lane array write; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (w_we[i]) r_mem[w_widx][8*i +: 8] <= w_wdat[8*i +: 8];
    end
endmodule

// File: tb/tb_agp32_mem_responder.sv
// tb_agp32_mem_responder: directed checks of load, fetch, read, write, interrupt, faults and reset
module tb_agp32_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n, load_done, ld_we, ready, mem_start_ready;
    logic [2:0]  command;
    logic [31:0] PC, data_addr, data_wdata, ld_data, inst_rdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic [9:0]  ld_addr;
    logic [1:0]  error;

    logic        b_rst_n, b_load_done, b_ld_we, b_ready, b_msr;
    logic [2:0]  b_command;
    logic [31:0] b_PC, b_data_addr, b_data_wdata, b_ld_data, b_inst, b_data;
    logic [3:0]  b_data_wstrb;
    logic [9:0]  b_ld_addr;
    logic [1:0]  b_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    agp32_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .command(command), .PC(PC), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .load_done(load_done), .ready(ready), .inst_rdata(inst_rdata),
        .data_rdata(data_rdata), .mem_start_ready(mem_start_ready), .error(error)
    );

    agp32_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(b_rst_n), .command(b_command), .PC(b_PC), .data_addr(b_data_addr),
        .data_wdata(b_data_wdata), .data_wstrb(b_data_wstrb), .ld_we(b_ld_we), .ld_addr(b_ld_addr),
        .ld_data(b_ld_data), .load_done(b_load_done), .ready(b_ready), .inst_rdata(b_inst),
        .data_rdata(b_data), .mem_start_ready(b_msr), .error(b_error)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    // Issues a one-cycle command and counts the cycles ready stays low (bounded).
    task automatic run_cmd(input logic [2:0] c, output int lat);
        command = c;
        tick();
        command = 3'd0;
        lat = 0;
        while (!ready && lat < 20) begin
            lat++;
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; b_rst_n = 1'b0; command = 3'd0; PC = 0; data_addr = 0; data_wdata = 0;
        data_wstrb = 0; ld_we = 0; ld_addr = 0; ld_data = 0; load_done = 0;
        b_command = 3'd0; b_PC = 0; b_data_addr = 0; b_data_wdata = 0; b_data_wstrb = 0;
        b_ld_we = 0; b_ld_addr = 0; b_ld_data = 0; b_load_done = 0;
        #2;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", ready); end
        total++; if (mem_start_ready !== 1'b0) begin bad++; $display("FAIL reset_msr got=%0h exp=0", mem_start_ready); end
        total++; if (error !== 2'd0) begin bad++; $display("FAIL reset_error got=%0h exp=0", error); end
        total++; if (inst_rdata !== 32'd0) begin bad++; $display("FAIL reset_inst got=%08h exp=0", inst_rdata); end
        total++; if (data_rdata !== 32'd0) begin bad++; $display("FAIL reset_data got=%08h exp=0", data_rdata); end
        tick();
        rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        total++; if (ready !== 1'b0 || mem_start_ready !== 1'b0) begin bad++; $display("FAIL load_wait got=%0h%0h exp=00", ready, mem_start_ready); end
    endtask

    task automatic test_startup;
        int lat;
        load_word(10'd0, 32'h0000_0A3F);
        load_word(10'd1, 32'h1234_5678);
        load_word(10'd2, 32'hAABB_CCDD);
        total++; if (ready !== 1'b0 || mem_start_ready !== 1'b0) begin bad++; $display("FAIL still_loading got=%0h%0h exp=00", ready, mem_start_ready); end
        ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'h3333_3333; load_done = 1'b1;
        command = 3'd1; PC = 32'd0;
        tick();
        ld_we = 1'b0; load_done = 1'b0; command = 3'd0;
        total++; if (mem_start_ready !== 1'b1) begin bad++; $display("FAIL start_msr got=%0h exp=1", mem_start_ready); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL start_ready got=%0h exp=1", ready); end
        total++; if (inst_rdata !== 32'd0) begin bad++; $display("FAIL load_cmd_ignored got=%08h exp=0", inst_rdata); end
        PC = 32'd4;
        run_cmd(3'd1, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL fetch_latency got=%0d exp=2", lat); end
        total++; if (inst_rdata !== 32'h1234_5678) begin bad++; $display("FAIL fetch_inst got=%08h exp=12345678", inst_rdata); end
        total++; if (error !== 2'd0) begin bad++; $display("FAIL fetch_error got=%0h exp=0", error); end
        total++; if (data_rdata !== 32'd0) begin bad++; $display("FAIL fetch_data_hold got=%08h exp=0", data_rdata); end
    endtask

    task automatic test_read;
        int lat;
        data_addr = 32'h0000_0006;
        run_cmd(3'd2, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL read_latency got=%0d exp=2", lat); end
        total++; if (data_rdata !== 32'h1234_5678) begin bad++; $display("FAIL read_data got=%08h exp=12345678", data_rdata); end
        total++; if (inst_rdata !== 32'h1234_5678) begin bad++; $display("FAIL read_inst_hold got=%08h exp=12345678", inst_rdata); end
    endtask

    task automatic test_byte_write;
        int lat;
        data_addr = 32'd8; data_wdata = 32'h0000_EE00; data_wstrb = 4'b0010;
        run_cmd(3'd3, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL write_latency got=%0d exp=2", lat); end
        run_cmd(3'd2, lat);
        total++; if (data_rdata !== 32'hAABB_EEDD) begin bad++; $display("FAIL byte_lane got=%08h exp=AABBEEDD", data_rdata); end
        data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b1111;
        run_cmd(3'd3, lat);
        run_cmd(3'd2, lat);
        total++; if (data_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL full_word got=%08h exp=DEADBEEF", data_rdata); end
        data_wdata = 32'h0000_0000; data_wstrb = 4'b0000;
        run_cmd(3'd3, lat);
        total++; if (error !== 2'd0 || ready !== 1'b1) begin bad++; $display("FAIL zero_strb_legal got=%0h/%0h exp=0/1", error, ready); end
        run_cmd(3'd2, lat);
        total++; if (data_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL zero_strb got=%08h exp=DEADBEEF", data_rdata); end
        data_wdata = 32'h1111_1111; data_wstrb = 4'b1111; data_addr = 32'd0;
        run_cmd(3'd3, lat);
        data_addr = 32'd4; data_wstrb = 4'b0100; data_wdata = 32'h0099_0000;
        run_cmd(3'd3, lat);
        data_addr = 32'd5;
        run_cmd(3'd2, lat);
        total++; if (data_rdata !== 32'h1299_5678) begin bad++; $display("FAIL lane2 got=%08h exp=12995678", data_rdata); end
        total++; if (inst_rdata !== 32'h1234_5678) begin bad++; $display("FAIL write_inst_hold got=%08h exp=12345678", inst_rdata); end
        PC = 32'd0;
        run_cmd(3'd1, lat);
        total++; if (inst_rdata !== 32'h1111_1111) begin bad++; $display("FAIL refetch got=%08h exp=11111111", inst_rdata); end
    endtask

    task automatic test_interrupt;
        int lat;
        run_cmd(3'd4, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL irq_latency got=%0d exp=2", lat); end
        total++; if (inst_rdata !== 32'h1111_1111 || data_rdata !== 32'h1299_5678) begin bad++; $display("FAIL irq_hold got=%08h/%08h exp=11111111/12995678", inst_rdata, data_rdata); end
        total++; if (error !== 2'd0) begin bad++; $display("FAIL irq_error got=%0h exp=0", error); end
        command = 3'd4;
        tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL held_accept got=%0h exp=0", ready); end
        tick();
        tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rise_not_accepted got=%0h exp=1", ready); end
        tick();
        command = 3'd0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL idle_accept got=%0h exp=0", ready); end
        tick();
        tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL held_done got=%0h exp=1", ready); end
    endtask

    task automatic test_reset_mid_busy;
        int lat;
        data_addr = 32'd12; data_wdata = 32'hFFFF_FFFF; data_wstrb = 4'b1111;
        command = 3'd3;
        tick();
        command = 3'd0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (ready !== 1'b0 || mem_start_ready !== 1'b0 || error !== 2'd0) begin bad++; $display("FAIL async_ctrl got=%0h%0h%0h exp=000", ready, mem_start_ready, error); end
        total++; if (inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin bad++; $display("FAIL async_rdata got=%08h/%08h exp=0/0", inst_rdata, data_rdata); end
        rst_n = 1'b1;
        tick();
        total++; if (mem_start_ready !== 1'b0) begin bad++; $display("FAIL back_to_load got=%0h exp=0", mem_start_ready); end
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        run_cmd(3'd2, lat);
        total++; if (data_rdata !== 32'h3333_3333) begin bad++; $display("FAIL no_partial_write got=%08h exp=33333333", data_rdata); end
        data_addr = 32'd8;
        run_cmd(3'd2, lat);
        total++; if (data_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mem_kept got=%08h exp=DEADBEEF", data_rdata); end
    endtask

    task automatic test_out_of_range;
        data_addr = 32'h0001_0000;
        command = 3'd2;
        tick();
        command = 3'd0;
        tick();
        total++; if (error !== 2'd0 || ready !== 1'b0) begin bad++; $display("FAIL oor_pending got=%0h/%0h exp=0/0", error, ready); end
        tick();
        total++; if (error !== 2'd1) begin bad++; $display("FAIL oor_error got=%0h exp=1", error); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL oor_ready got=%0h exp=0", ready); end
        total++; if (data_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL oor_no_update got=%08h exp=DEADBEEF", data_rdata); end
        PC = 32'd4; command = 3'd1;
        repeat (4) tick();
        command = 3'd0;
        total++; if (ready !== 1'b0 || error !== 2'd1 || inst_rdata !== 32'd0) begin bad++; $display("FAIL err_sticky got=%0h/%0h/%08h exp=0/1/0", ready, error, inst_rdata); end
    endtask

    task automatic test_illegal;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        total++; if (ready !== 1'b1 || error !== 2'd0) begin bad++; $display("FAIL pre_illegal got=%0h/%0h exp=1/0", ready, error); end
        command = 3'd6;
        tick();
        command = 3'd0;
        total++; if (error !== 2'd2 || ready !== 1'b0) begin bad++; $display("FAIL illegal got=%0h/%0h exp=2/0", error, ready); end
        PC = 32'd4; command = 3'd1;
        repeat (3) tick();
        command = 3'd0;
        total++; if (error !== 2'd2 || ready !== 1'b0 || inst_rdata !== 32'd0) begin bad++; $display("FAIL illegal_sticky got=%0h/%0h/%08h exp=2/0/0", error, ready, inst_rdata); end
    endtask

    task automatic test_latency1;
        b_ld_we = 1'b1; b_ld_addr = 10'd0; b_ld_data = 32'h0000_0011; b_load_done = 1'b1;
        tick();
        b_ld_we = 1'b0; b_load_done = 1'b0;
        total++; if (b_ready !== 1'b1 || b_msr !== 1'b1) begin bad++; $display("FAIL l1_start got=%0h%0h exp=11", b_ready, b_msr); end
        b_PC = 32'd0; b_command = 3'd1;
        tick();
        b_command = 3'd0;
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_fetch_low got=%0h exp=0", b_ready); end
        tick();
        total++; if (b_ready !== 1'b1 || b_inst !== 32'h0000_0011) begin bad++; $display("FAIL l1_fetch got=%0h/%08h exp=1/00000011", b_ready, b_inst); end
        b_data_addr = 32'd0; b_data_wdata = 32'h0000_00AA; b_data_wstrb = 4'b0001; b_command = 3'd3;
        tick();
        b_command = 3'd0;
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_write_low got=%0h exp=0", b_ready); end
        tick();
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL l1_write_done got=%0h exp=1", b_ready); end
        b_command = 3'd2;
        tick();
        b_command = 3'd0;
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_read_low got=%0h exp=0", b_ready); end
        tick();
        total++; if (b_ready !== 1'b1 || b_data !== 32'h0000_00AA) begin bad++; $display("FAIL l1_read got=%0h/%08h exp=1/000000AA", b_ready, b_data); end
        b_command = 3'd4;
        tick();
        b_command = 3'd0;
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_irq_low got=%0h exp=0", b_ready); end
        tick();
        total++; if (b_ready !== 1'b1 || b_error !== 2'd0) begin bad++; $display("FAIL l1_irq got=%0h/%0h exp=1/0", b_ready, b_error); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_read();
        test_byte_write();
        test_interrupt();
        test_reset_mid_busy();
        test_out_of_range();
        test_illegal();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
